// File: rtl/tcp_rx_parser.sv
// tcp_rx_parser: receive-side TCP segment parser.
// Walks the header of an incoming segment byte stream, skips options, passes
// payload through with backpressure, and raises one-cycle event strobes for
// the connection-control FSM one cycle after the last byte is accepted.
// Build option: define TCP_RX_PORT_FILTER_EN to drop segments whose
// destination port differs from the effective local port.
module tcp_rx_parser #(
  parameter logic [15:0] DEFAULT_LOCAL_PORT = 16'h1F90,
  parameter logic [3:0]  MIN_DOFF           = 4'd5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tlast,
  input  logic [15:0] local_port_in,
  input  logic [31:0] expected_ack_in,
  input  logic        fin_sent_in,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        syn_rcvd,
  output logic        fin_rcvd,
  output logic        ack_rcvd,
  output logic        rst_rcvd,
  output logic        syn_ack_rcvd,
  output logic        fin_ack_rcvd,
  output logic        hdr_err,
  output logic        drop_pulse,
  output logic [15:0] rx_src_port,
  output logic [31:0] rx_seq_num,
  output logic [31:0] rx_ack_num,
  output logic [15:0] rx_window
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_OPTIONS,
    ST_PAYLOAD,
    ST_DROP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_run;
  logic [5:0]  r_cnt;
  logic        w_accept;
  logic        w_hdr_err;
  logic        w_good;
  logic [5:0]  w_hdr_last;
  logic        w_ack_match;

  // header shadow registers
  logic [15:0] r_sh_src;
  logic [31:0] r_sh_seq;
  logic [31:0] r_sh_ack;
  logic [3:0]  r_sh_doff;
  logic        r_sh_fin;
  logic        r_sh_syn;
  logic        r_sh_rst;
  logic        r_sh_ackf;
  logic [15:0] r_sh_win;

  // event strobes and published fields
  logic        r_syn;
  logic        r_fin;
  logic        r_ack;
  logic        r_rst;
  logic        r_synack;
  logic        r_finack;
  logic        r_hdr_err;
  logic [15:0] r_rx_src;
  logic [31:0] r_rx_seq;
  logic [31:0] r_rx_ack;
  logic [15:0] r_rx_win;

`ifdef TCP_RX_PORT_FILTER_EN
  logic [7:0]  r_sh_dst_hi;
  logic [15:0] w_local_port;
  logic        w_drop;
  logic        r_drop;
  assign w_local_port = (local_port_in == 16'h0) ? DEFAULT_LOCAL_PORT : local_port_in;
  assign drop_pulse   = r_drop;
`else
  logic        w_unused_port;
  assign w_unused_port = ^local_port_in;
  assign drop_pulse    = 1'b0;
`endif

  // s_tready is held low until the first clock after reset release
  assign s_tready    = r_run & ((r_state == ST_PAYLOAD) ? m_tready : 1'b1);
  assign w_accept    = s_tvalid & s_tready;
  assign w_hdr_last  = {r_sh_doff, 2'b00} - 6'd1;
  assign w_ack_match = r_sh_ackf & (r_sh_ack == expected_ack_in);

  assign m_tvalid = (r_state == ST_PAYLOAD) & s_tvalid;
  assign m_tdata  = (r_state == ST_PAYLOAD) ? s_tdata : 8'h00;
  assign m_tlast  = (r_state == ST_PAYLOAD) & s_tlast;

  assign syn_rcvd     = r_syn;
  assign fin_rcvd     = r_fin;
  assign ack_rcvd     = r_ack;
  assign rst_rcvd     = r_rst;
  assign syn_ack_rcvd = r_synack;
  assign fin_ack_rcvd = r_finack;
  assign hdr_err      = r_hdr_err;
  assign rx_src_port  = r_rx_src;
  assign rx_seq_num   = r_rx_seq;
  assign rx_ack_num   = r_rx_ack;
  assign rx_window    = r_rx_win;

  // state register and post-reset ready enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= 1'b1;
    end
  end

  // next-state decode plus completion/error/drop qualifiers for the accepted byte
  always_comb begin
    w_state_nxt = r_state;
    w_hdr_err   = 1'b0;
    w_good      = 1'b0;
`ifdef TCP_RX_PORT_FILTER_EN
    w_drop      = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (s_tlast) w_hdr_err = 1'b1;
          else         w_state_nxt = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (w_accept) begin
          if ((r_cnt == 6'd12) && (s_tdata[7:4] < MIN_DOFF)) begin
            w_hdr_err   = 1'b1;
            w_state_nxt = s_tlast ? ST_IDLE : ST_DROP;
          end else if (r_cnt == 6'd19) begin
            if (s_tlast) begin
              w_good      = 1'b1;
              w_state_nxt = ST_IDLE;
            end else if (r_sh_doff > MIN_DOFF) begin
              w_state_nxt = ST_OPTIONS;
            end else begin
              w_state_nxt = ST_PAYLOAD;
            end
          end else if (s_tlast) begin
            w_hdr_err   = 1'b1;
            w_state_nxt = ST_IDLE;
`ifdef TCP_RX_PORT_FILTER_EN
          end else if ((r_cnt == 6'd3) && ({r_sh_dst_hi, s_tdata} != w_local_port)) begin
            w_drop      = 1'b1;
            w_state_nxt = ST_DROP;
`endif
          end
        end
      end
      ST_OPTIONS: begin
        if (w_accept) begin
          if (r_cnt == w_hdr_last) begin
            if (s_tlast) begin
              w_good      = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_state_nxt = ST_PAYLOAD;
            end
          end else if (s_tlast) begin
            w_hdr_err   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_PAYLOAD: begin
        if (w_accept && s_tlast) begin
          w_good      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (w_accept && s_tlast) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // byte counter and header field capture into shadow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 6'd0;
      r_sh_src  <= 16'h0;
      r_sh_seq  <= 32'h0;
      r_sh_ack  <= 32'h0;
      r_sh_doff <= 4'h0;
      r_sh_fin  <= 1'b0;
      r_sh_syn  <= 1'b0;
      r_sh_rst  <= 1'b0;
      r_sh_ackf <= 1'b0;
      r_sh_win  <= 16'h0;
`ifdef TCP_RX_PORT_FILTER_EN
      r_sh_dst_hi <= 8'h0;
`endif
    end else if (w_accept) begin
      if (w_state_nxt == ST_IDLE)
        r_cnt <= 6'd0;
      else if ((r_state == ST_IDLE) || (r_state == ST_HEADER) || (r_state == ST_OPTIONS))
        r_cnt <= r_cnt + 6'd1;
      if (r_state == ST_IDLE)
        r_sh_src[15:8] <= s_tdata;
      if (r_state == ST_HEADER) begin
        case (r_cnt)
          6'd1:  r_sh_src[7:0]   <= s_tdata;
`ifdef TCP_RX_PORT_FILTER_EN
          6'd2:  r_sh_dst_hi     <= s_tdata;
`endif
          6'd4:  r_sh_seq[31:24] <= s_tdata;
          6'd5:  r_sh_seq[23:16] <= s_tdata;
          6'd6:  r_sh_seq[15:8]  <= s_tdata;
          6'd7:  r_sh_seq[7:0]   <= s_tdata;
          6'd8:  r_sh_ack[31:24] <= s_tdata;
          6'd9:  r_sh_ack[23:16] <= s_tdata;
          6'd10: r_sh_ack[15:8]  <= s_tdata;
          6'd11: r_sh_ack[7:0]   <= s_tdata;
          6'd12: r_sh_doff       <= s_tdata[7:4];
          6'd13: begin
            r_sh_fin  <= s_tdata[0];
            r_sh_syn  <= s_tdata[1];
            r_sh_rst  <= s_tdata[2];
            r_sh_ackf <= s_tdata[4];
          end
          6'd14: r_sh_win[15:8]  <= s_tdata;
          6'd15: r_sh_win[7:0]   <= s_tdata;
          default: ;
        endcase
      end
    end
  end

  // one-cycle event strobes and publication of the last good segment's fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_syn     <= 1'b0;
      r_fin     <= 1'b0;
      r_ack     <= 1'b0;
      r_rst     <= 1'b0;
      r_synack  <= 1'b0;
      r_finack  <= 1'b0;
      r_hdr_err <= 1'b0;
      r_rx_src  <= 16'h0;
      r_rx_seq  <= 32'h0;
      r_rx_ack  <= 32'h0;
      r_rx_win  <= 16'h0;
`ifdef TCP_RX_PORT_FILTER_EN
      r_drop    <= 1'b0;
`endif
    end else begin
      r_syn     <= w_good & r_sh_syn;
      r_fin     <= w_good & r_sh_fin;
      r_rst     <= w_good & r_sh_rst;
      r_ack     <= w_good & w_ack_match;
      r_synack  <= w_good & r_sh_syn & w_ack_match;
      r_finack  <= w_good & w_ack_match & fin_sent_in;
      r_hdr_err <= w_hdr_err;
`ifdef TCP_RX_PORT_FILTER_EN
      r_drop    <= w_drop;
`endif
      if (w_good) begin
        r_rx_src <= r_sh_src;
        r_rx_seq <= r_sh_seq;
        r_rx_ack <= r_sh_ack;
        r_rx_win <= r_sh_win;
      end
    end
  end

endmodule

// File: doc/tcp_rx_parser.md
Name: tcp_rx_parser

Overview:
- Receive-side TCP segment parser: consumes byte stream of TCP segment (IP header already stripped), decodes header, raises the one-cycle event strobes consumed by the TCP connection-control FSM (syn_rcvd, fin_rcvd, ack_rcvd, syn_ack_rcvd, fin_ack_rcvd).
- Extracts sequence/ack/window fields; forwards payload bytes downstream with backpressure.
- Sits between IP RX demux and control FSM / RX data buffer.

Parameters:
- DEFAULT_LOCAL_PORT, 16'h1F90: local port used when local_port_in == 0.
- MIN_DOFF, 4'd5: minimum legal data offset (32-bit words).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- s_tdata  in  8  segment byte, network order
- s_tvalid  in  1  input byte valid
- s_tready  out  1  input byte accepted when s_tvalid & s_tready
- s_tlast  in  1  last byte of segment
- local_port_in  in  16  local TCP port from register bank (0 = use default)
- expected_ack_in  in  32  ack number that acknowledges our outstanding data/SYN/FIN
- fin_sent_in  in  1  our FIN is outstanding
- m_tdata  out  8  payload byte
- m_tvalid  out  1  payload byte valid
- m_tready  in  1  downstream ready
- m_tlast  out  1  last payload byte
- syn_rcvd, fin_rcvd, ack_rcvd, rst_rcvd, syn_ack_rcvd, fin_ack_rcvd  out  1 each  one-cycle event strobes
- hdr_err  out  1  one-cycle strobe: malformed segment
- drop_pulse  out  1  one-cycle strobe: segment filtered
- rx_src_port  out  16;  rx_seq_num  out  32;  rx_ack_num  out  32;  rx_window  out  16  fields of last good segment

Behaviour:
- Reset: all outputs 0; state IDLE; byte counter 0; s_tready 0 during reset, 1 in IDLE after reset.
- States: IDLE, HEADER, OPTIONS, PAYLOAD, DROP. IDLE→HEADER on first accepted byte (byte 0 captured same cycle).
- Byte counter 6 bits, counts accepted bytes from 0. Header bytes big-endian: 0-1 src port, 2-3 dst port, 4-7 seq, 8-11 ack, 12[7:4] data offset, 13 flags (bit0 FIN, 1 SYN, 2 RST, 4 ACK), 14-15 window, 16-19 ignored. Captured into shadow registers.
- s_tready = 1 in IDLE/HEADER/OPTIONS/DROP; = m_tready in PAYLOAD.
- After byte 12: doff < MIN_DOFF → hdr_err next cycle, go DROP (or IDLE if that byte had s_tlast).
- After byte 19: doff > 5 → OPTIONS, skip bytes until count == doff*4-1; then PAYLOAD. doff == 5 → PAYLOAD.
- PAYLOAD: m_tdata = s_tdata, m_tvalid = s_tvalid, m_tlast = s_tlast, combinational pass-through; m_tvalid 0 in all other states.
- s_tlast before header+options complete → hdr_err, no event strobes, state IDLE.
- Good completion (s_tlast accepted at/after final header byte): next cycle copy shadows to rx_* outputs and strobe: syn_rcvd = SYN; fin_rcvd = FIN; rst_rcvd = RST; ack_match = ACK & (ack == expected_ack_in); ack_rcvd = ack_match; syn_ack_rcvd = SYN & ack_match; fin_ack_rcvd = ack_match & fin_sent_in (sampled at completion). Multiple strobes may assert together.
- Latency: strobes exactly 1 cycle after last byte accepted. Back-to-back segments: byte 0 of next segment accepted in the strobe cycle without loss.
- DROP: accept and discard until s_tlast, then IDLE; no strobes.
- Reset mid-segment: everything to reset values; partial segment discarded, no strobes.

Optional Feature:
- TCP_RX_PORT_FILTER_EN defined: after byte 3, dst port != effective local port → drop_pulse next cycle, DROP, no strobes, no payload. Undefined: dst port ignored, drop_pulse tied 0.

Test Plan:
- 20-byte segment flags 0x12, seq 0x0000A000, ack 0x00001001, expected_ack_in 0x00001001 → 1 cycle after tlast: syn_rcvd, ack_rcvd, syn_ack_rcvd high one cycle; rx_seq_num 0x0000A000; m_tvalid never high.
- doff 6 header (24 bytes) + payload 0xDE 0xAD 0xBE 0xEF, m_tready toggling 1/0 → 4 bytes out in order, m_tlast with 0xEF, option bytes not forwarded, no byte lost or duplicated.
- 12-byte frame with tlast → hdr_err one cycle, no event strobes, next 20-byte segment parsed correctly.
- flags 0x11, ack match, fin_sent_in 1 → fin_rcvd, ack_rcvd, fin_ack_rcvd; repeat with ack 0x00001000 → fin_rcvd only.
- With TCP_RX_PORT_FILTER_EN, dst 0x0050, local_port_in 0 (default 0x1F90) → drop_pulse, no strobes; without macro same stimulus → strobes per flags.
- rst_n asserted mid-payload → all outputs 0 immediately; after release, back-to-back segments produce correct strobes.
